// File: rtl/decode_pkg.sv
// Shared decode constants: opcodes, branch funct3 codes, forward selects and the
// immediate extractor used by the ID stage.
package decode_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [1:0] {
    FWD_RF   = 2'd0,
    FWD_ALUM = 2'd1,
    FWD_MEMD = 2'd2,
    FWD_WB   = 2'd3
  } fwd_sel_e;

  // 32-bit sign-carrying immediate; the caller widens it to XLEN.
  function automatic logic [31:0] imm32(input logic [31:0] i);
    case (i[6:0])
      OP_IMM, OP_LOAD, OP_JALR: return {{20{i[31]}}, i[31:20]};
      OP_STORE:                 return {{20{i[31]}}, i[31:25], i[11:7]};
      OP_BRANCH:                return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      OP_LUI, OP_AUIPC:         return {i[31:12], 12'b0};
      OP_JAL:                   return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      default:                  return 32'b0;
    endcase
  endfunction

endpackage

// File: rtl/decode_stage_gen_regfile.sv
// Integer register file: two write-through read ports, one write port, x0 hardwired.
// Define DECODE_DBG_PORT_EN to add a third raw read port (no write-through).
module regfile_gen #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  localparam int AW  = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [AW-1:0]   raddr1,
  input  logic [AW-1:0]   raddr2,
  output logic [XLEN-1:0] rdata1,
  output logic [XLEN-1:0] rdata2
`ifdef DECODE_DBG_PORT_EN
  ,
  input  logic [AW-1:0]   dbg_addr,
  output logic [XLEN-1:0] dbg_data
`endif
);

  logic [NREG-1:0][XLEN-1:0] regs;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         regs <= '0;
    else if (we && waddr != '0)      regs[waddr] <= wdata;
  end

  function automatic logic [XLEN-1:0] rd_port(input logic [AW-1:0] a);
    if (a == '0)               return '0;
    if (we && waddr == a)      return wdata;
    return regs[a];
  endfunction

  always_comb begin
    rdata1 = rd_port(raddr1);
    rdata2 = rd_port(raddr2);
  end

`ifdef DECODE_DBG_PORT_EN
  always_comb begin
    dbg_data = '0;
    if (!rst && dbg_addr != '0) dbg_data = regs[dbg_addr];
  end
`endif

endmodule

// File: rtl/decode_stage_gen.sv
// ID stage: register file, immediate generation, branch/JAL resolution and the ID/EX register.
// Define DECODE_DBG_PORT_EN to expose DbgAddr/DbgData (raw register-file read).
module decode_stage_gen
  import decode_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int NREG   = 32,
  parameter int CTRL_W = 8,
  localparam int AW    = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       InstrD,
  input  logic [XLEN-1:0]   PCD,
  input  logic              ValidD,
  input  logic [CTRL_W-1:0] CtrlD,
  input  logic              BranchD,
  input  logic              JumpD,
  input  logic              RegWriteW,
  input  logic [AW-1:0]     WriteRegW,
  input  logic [XLEN-1:0]   ResultW,
  input  logic [XLEN-1:0]   ALUOutM,
  input  logic [XLEN-1:0]   ReadDataM,
  input  logic [1:0]        ForwardAD,
  input  logic [1:0]        ForwardBD,
  input  logic              StallE,
  input  logic              FlushE,
  output logic              PCSrcD,
  output logic [XLEN-1:0]   PCTargetD,
  output logic [CTRL_W-1:0] CtrlE,
  output logic              ValidE,
  output logic [XLEN-1:0]   RD1E,
  output logic [XLEN-1:0]   RD2E,
  output logic [XLEN-1:0]   ImmE,
  output logic [XLEN-1:0]   PCE,
  output logic [AW-1:0]     RS1E,
  output logic [AW-1:0]     RS2E,
  output logic [AW-1:0]     RdE
`ifdef DECODE_DBG_PORT_EN
  ,
  input  logic [AW-1:0]     DbgAddr,
  output logic [XLEN-1:0]   DbgData
`endif
);

  logic [AW-1:0]          rs1, rs2, rd;
  logic [XLEN-1:0]        rd1, rd2, imm, op_a, op_b;
  logic signed [31:0]     imm_s;
  logic                   taken;

  assign rs1 = InstrD[15 +: AW];
  assign rs2 = InstrD[20 +: AW];
  assign rd  = InstrD[7 +: AW];

  regfile_gen #(.XLEN(XLEN), .NREG(NREG)) u_rf (
    .clk(clk), .rst(rst),
    .we(RegWriteW), .waddr(WriteRegW), .wdata(ResultW),
    .raddr1(rs1), .raddr2(rs2), .rdata1(rd1), .rdata2(rd2)
`ifdef DECODE_DBG_PORT_EN
    , .dbg_addr(DbgAddr), .dbg_data(DbgData)
`endif
  );

  assign imm_s = imm32(InstrD);
  assign imm   = XLEN'(imm_s);

  function automatic logic [XLEN-1:0] fwd_mux(input logic [1:0] sel, input logic [XLEN-1:0] rf);
    case (fwd_sel_e'(sel))
      FWD_ALUM: return ALUOutM;
      FWD_MEMD: return ReadDataM;
      FWD_WB:   return ResultW;
      default:  return rf;
    endcase
  endfunction

  always_comb begin
    op_a = fwd_mux(ForwardAD, rd1);
    op_b = fwd_mux(ForwardBD, rd2);
  end

  // Direct relational compares avoid the overflow pitfall of a subtract-and-sign test.
  always_comb begin
    taken = 1'b0;
    case (InstrD[14:12])
      F3_BEQ:  taken = (op_a == op_b);
      F3_BNE:  taken = (op_a != op_b);
      F3_BLT:  taken = ($signed(op_a) <  $signed(op_b));
      F3_BGE:  taken = ($signed(op_a) >= $signed(op_b));
      F3_BLTU: taken = (op_a <  op_b);
      F3_BGEU: taken = (op_a >= op_b);
      default: taken = 1'b0;
    endcase
  end

  assign PCSrcD    = ValidD & ((BranchD & taken) | JumpD);
  assign PCTargetD = PCD + imm;

  // EX operands carry raw RF reads; EX applies its own forwarding.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      CtrlE <= '0; ValidE <= 1'b0;
      RD1E  <= '0; RD2E   <= '0; ImmE <= '0; PCE <= '0;
      RS1E  <= '0; RS2E   <= '0; RdE  <= '0;
    end else if (FlushE) begin
      CtrlE <= '0; ValidE <= 1'b0;
      RD1E  <= '0; RD2E   <= '0; ImmE <= '0; PCE <= '0;
      RS1E  <= '0; RS2E   <= '0; RdE  <= '0;
    end else if (!StallE) begin
      CtrlE  <= ValidD ? CtrlD : '0;
      ValidE <= ValidD;
      RD1E   <= rd1;
      RD2E   <= rd2;
      ImmE   <= imm;
      PCE    <= PCD;
      RS1E   <= rs1;
      RS2E   <= rs2;
      RdE    <= rd;
    end
  end

endmodule

// File: tb/tb_decode_stage_gen.sv
// Scoreboard bench for decode_stage_gen: stimulus queues expected values with a due cycle,
// a monitor pops and compares them at the falling edge (or on an explicit mid-cycle probe).
module tb_decode_stage_gen;

  localparam int XLEN = 32, NREG = 32, CTRL_W = 8, AW = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic [31:0]       InstrD;
  logic [XLEN-1:0]   PCD, ResultW, ALUOutM, ReadDataM;
  logic              ValidD, BranchD, JumpD, RegWriteW, StallE, FlushE;
  logic [CTRL_W-1:0] CtrlD;
  logic [AW-1:0]     WriteRegW;
  logic [1:0]        ForwardAD, ForwardBD;
  logic              PCSrcD, ValidE;
  logic [XLEN-1:0]   PCTargetD, RD1E, RD2E, ImmE, PCE;
  logic [CTRL_W-1:0] CtrlE;
  logic [AW-1:0]     RS1E, RS2E, RdE;

  decode_stage_gen #(.XLEN(XLEN), .NREG(NREG), .CTRL_W(CTRL_W)) dut (
    .clk(clk), .rst(rst), .InstrD(InstrD), .PCD(PCD), .ValidD(ValidD), .CtrlD(CtrlD),
    .BranchD(BranchD), .JumpD(JumpD), .RegWriteW(RegWriteW), .WriteRegW(WriteRegW),
    .ResultW(ResultW), .ALUOutM(ALUOutM), .ReadDataM(ReadDataM),
    .ForwardAD(ForwardAD), .ForwardBD(ForwardBD), .StallE(StallE), .FlushE(FlushE),
    .PCSrcD(PCSrcD), .PCTargetD(PCTargetD), .CtrlE(CtrlE), .ValidE(ValidE),
    .RD1E(RD1E), .RD2E(RD2E), .ImmE(ImmE), .PCE(PCE), .RS1E(RS1E), .RS2E(RS2E), .RdE(RdE)
  );

  always #5 clk = ~clk;

  typedef enum {S_PCSRC, S_TGT, S_VALIDE, S_CTRLE, S_RD1E, S_RD2E, S_IMME, S_PCE,
                S_RS1E, S_RS2E, S_RDE} sig_e;
  typedef struct {
    string       name;
    sig_e        sel;
    logic [31:0] val;
    int          due;
    bit          now;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  event probe;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] actual(input sig_e s);
    case (s)
      S_PCSRC:  return 32'(PCSrcD);
      S_TGT:    return PCTargetD;
      S_VALIDE: return 32'(ValidE);
      S_CTRLE:  return 32'(CtrlE);
      S_RD1E:   return RD1E;
      S_RD2E:   return RD2E;
      S_IMME:   return ImmE;
      S_PCE:    return PCE;
      S_RS1E:   return 32'(RS1E);
      S_RS2E:   return 32'(RS2E);
      default:  return 32'(RdE);
    endcase
  endfunction

  task automatic check(input bit now);
    int i = 0;
    logic [31:0] a;
    while (i < sb.size()) begin
      if (sb[i].now == now && (now || sb[i].due <= cyc)) begin
        total++;
        a = actual(sb[i].sel);
        if (a !== sb[i].val) begin
          bad++;
          $display("FAIL %s: got %h want %h (cycle %0d)", sb[i].name, a, sb[i].val, cyc);
        end
        sb.delete(i);
      end else begin
        i++;
      end
    end
  endtask

  always @(negedge clk) check(1'b0);
  always @(probe)       check(1'b1);

  task automatic push(input string n, input sig_e s, input logic [31:0] v, input int lat);
    exp_t e;
    e.name = n; e.sel = s; e.val = v; e.due = cyc + lat; e.now = 1'b0;
    sb.push_back(e);
  endtask

  task automatic push_now(input string n, input sig_e s, input logic [31:0] v);
    exp_t e;
    e.name = n; e.sel = s; e.val = v; e.due = cyc; e.now = 1'b1;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] enc_b(input int imm, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3);
    logic [12:0] im;
    im = 13'(imm);
    return {im[12], im[10:5], rs2, rs1, f3, im[4:1], im[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_i(input int imm, input logic [4:0] rs1, input logic [4:0] rd);
    logic [11:0] im;
    im = 12'(imm);
    return {im, rs1, 3'b000, rd, 7'b0010011};
  endfunction

  function automatic logic [31:0] enc_s(input int imm, input logic [4:0] rs2, input logic [4:0] rs1);
    logic [11:0] im;
    im = 12'(imm);
    return {im[11:5], rs2, rs1, 3'b010, im[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] enc_j(input int imm, input logic [4:0] rd);
    logic [20:0] im;
    im = 21'(imm);
    return {im[20], im[10:1], im[11], im[19:12], rd, 7'b1101111};
  endfunction

  task automatic drive_br(input logic [2:0] f3, input logic [4:0] rs1, input logic [4:0] rs2,
                          input int imm, input logic [31:0] pc);
    InstrD = enc_b(imm, rs2, rs1, f3); PCD = pc; BranchD = 1'b1; JumpD = 1'b0; ValidD = 1'b1;
  endtask

  initial begin
    rst = 1'b1; InstrD = '0; PCD = '0; ValidD = 1'b0; CtrlD = '0; BranchD = 1'b0; JumpD = 1'b0;
    RegWriteW = 1'b0; WriteRegW = '0; ResultW = '0; ALUOutM = '0; ReadDataM = '0;
    ForwardAD = 2'd0; ForwardBD = 2'd0; StallE = 1'b0; FlushE = 1'b0;

    // reset state
    step();
    push("rst_valid", S_VALIDE, 0, 0); push("rst_ctrl", S_CTRLE, 0, 0);
    push("rst_rd1", S_RD1E, 0, 0);     push("rst_pc", S_PCE, 0, 0);
    step(); rst = 1'b0;

    // x5 = 0x10, x6 = 0xFFFF_FFF0, then signed/unsigned branches
    step(); RegWriteW = 1'b1; WriteRegW = 5'd5; ResultW = 32'h10;
    step(); WriteRegW = 5'd6; ResultW = 32'hFFFF_FFF0;
    step(); RegWriteW = 1'b0; CtrlD = 8'hA5; drive_br(3'b100, 5'd6, 5'd5, 8, 32'h100);
    push("blt_pcsrc", S_PCSRC, 1, 0); push("blt_tgt", S_TGT, 32'h108, 0);
    push("blt_rd1e", S_RD1E, 32'hFFFF_FFF0, 1); push("blt_rd2e", S_RD2E, 32'h10, 1);
    push("blt_imme", S_IMME, 8, 1); push("blt_pce", S_PCE, 32'h100, 1);
    push("blt_rs1e", S_RS1E, 6, 1); push("blt_rs2e", S_RS2E, 5, 1);
    push("blt_valide", S_VALIDE, 1, 1); push("blt_ctrle", S_CTRLE, 32'hA5, 1);
    step(); drive_br(3'b110, 5'd6, 5'd5, 8, 32'h100); push("bltu_pcsrc", S_PCSRC, 0, 0);
    step(); drive_br(3'b101, 5'd6, 5'd5, 8, 32'h100); push("bge_pcsrc", S_PCSRC, 0, 0);
    step(); drive_br(3'b111, 5'd6, 5'd5, 8, 32'h100); push("bgeu_pcsrc", S_PCSRC, 1, 0);

    // MIN vs MAX through forwarding
    step(); ForwardAD = 2'd1; ALUOutM = 32'h8000_0000; ForwardBD = 2'd2; ReadDataM = 32'h7FFF_FFFF;
    drive_br(3'b100, 5'd1, 5'd2, 8, 32'h100); push("blt_minmax", S_PCSRC, 1, 0);
    step(); drive_br(3'b110, 5'd1, 5'd2, 8, 32'h100); push("bltu_minmax", S_PCSRC, 0, 0);
    step(); ReadDataM = 32'h8000_0000; drive_br(3'b010, 5'd1, 5'd2, 8, 32'h100);
    push("f3_010", S_PCSRC, 0, 0);
    step(); drive_br(3'b001, 5'd1, 5'd2, 8, 32'h100); push("bne_equal", S_PCSRC, 0, 0);
    ForwardAD = 2'd0; ForwardBD = 2'd0;

    // write-through x7, negative I immediate
    step(); BranchD = 1'b0; ValidD = 1'b1; InstrD = enc_i(-1, 5'd7, 5'd1); PCD = 32'h200;
    RegWriteW = 1'b1; WriteRegW = 5'd7; ResultW = 32'hABCD;
    push("wt_pcsrc", S_PCSRC, 0, 0); push("wt_tgt", S_TGT, 32'h1FF, 0);
    push("wt_rd1e", S_RD1E, 32'hABCD, 1); push("i_imm_neg", S_IMME, 32'hFFFF_FFFF, 1);
    // x0 write ignored, including write-through
    step(); WriteRegW = 5'd0; ResultW = 32'h1234; InstrD = enc_i(0, 5'd0, 5'd1);
    push("x0_wt", S_RD1E, 0, 1);
    step(); RegWriteW = 1'b0; InstrD = {7'b0, 5'd7, 5'd0, 3'b000, 5'd1, 7'b0110011};
    push("x0_read", S_RD1E, 0, 1); push("x7_kept", S_RD2E, 32'hABCD, 1);
    push("rtype_imm0", S_IMME, 0, 1);

    // forwarded BEQ with differing RF values
    step(); RegWriteW = 1'b1; WriteRegW = 5'd1; ResultW = 32'h11; ValidD = 1'b0;
    step(); RegWriteW = 1'b0; drive_br(3'b000, 5'd1, 5'd2, -4, 32'h300);
    ForwardAD = 2'd1; ALUOutM = 32'h55; ForwardBD = 2'd2; ReadDataM = 32'h55;
    push("beq_fwd", S_PCSRC, 1, 0); push("beq_tgt", S_TGT, 32'h2FC, 0);
    push("beq_rd1e_raw", S_RD1E, 32'h11, 1); push("beq_rd2e_raw", S_RD2E, 0, 1);
    step(); ForwardBD = 2'd3; ResultW = 32'h56; push("beq_fwd_wb", S_PCSRC, 0, 0);
    step(); ForwardBD = 2'd1; ValidD = 1'b0; push("beq_invalid", S_PCSRC, 0, 0);
    step(); ForwardAD = 2'd0; ForwardBD = 2'd0; BranchD = 1'b0;

    // stall holds, flush beats stall
    step(); ValidD = 1'b1; CtrlD = 8'h3C; InstrD = enc_i(32'h7F, 5'd5, 5'd3); PCD = 32'h400;
    push("ld_valide", S_VALIDE, 1, 1); push("ld_ctrle", S_CTRLE, 32'h3C, 1);
    push("ld_rd1e", S_RD1E, 32'h10, 1); push("ld_imme", S_IMME, 32'h7F, 1);
    push("ld_pce", S_PCE, 32'h400, 1); push("ld_rde", S_RDE, 3, 1); push("ld_rs1e", S_RS1E, 5, 1);
    for (int k = 0; k < 3; k++) begin
      step(); StallE = 1'b1; CtrlD = 8'hFF; PCD = 32'h500 + 32'(k * 4);
      InstrD = enc_i(k + 1, 5'd6, 5'd9);
      push("stall_valide", S_VALIDE, 1, 1); push("stall_ctrle", S_CTRLE, 32'h3C, 1);
      push("stall_rd1e", S_RD1E, 32'h10, 1); push("stall_imme", S_IMME, 32'h7F, 1);
      push("stall_pce", S_PCE, 32'h400, 1); push("stall_rde", S_RDE, 3, 1);
    end
    step(); FlushE = 1'b1;
    push("fl_valide", S_VALIDE, 0, 1); push("fl_ctrle", S_CTRLE, 0, 1);
    push("fl_rd1e", S_RD1E, 0, 1);     push("fl_rd2e", S_RD2E, 0, 1);
    push("fl_imme", S_IMME, 0, 1);     push("fl_pce", S_PCE, 0, 1);
    push("fl_rs1e", S_RS1E, 0, 1);     push("fl_rs2e", S_RS2E, 0, 1);
    push("fl_rde", S_RDE, 0, 1);
    step(); FlushE = 1'b0; StallE = 1'b0;

    // JAL wrap, invalid gating, U and S immediates
    step(); InstrD = enc_j(8, 5'd1); PCD = 32'hFFFF_FFFC; JumpD = 1'b1; ValidD = 1'b1; CtrlD = 8'h81;
    push("jal_pcsrc", S_PCSRC, 1, 0); push("jal_wrap", S_TGT, 32'h4, 0);
    push("jal_valide", S_VALIDE, 1, 1); push("jal_ctrle", S_CTRLE, 32'h81, 1);
    push("jal_imme", S_IMME, 8, 1);
    step(); ValidD = 1'b0;
    push("jal_inv_pcsrc", S_PCSRC, 0, 0); push("inv_ctrle", S_CTRLE, 0, 1);
    push("inv_valide", S_VALIDE, 0, 1);
    step(); JumpD = 1'b0; ValidD = 1'b1; CtrlD = 8'h00; InstrD = {20'h12345, 5'd2, 7'b0110111};
    push("lui_imme", S_IMME, 32'h1234_5000, 1);
    step(); InstrD = enc_s(-8, 5'd5, 5'd6); PCD = 32'h40;
    push("s_imme", S_IMME, 32'hFFFF_FFF8, 1); push("s_tgt", S_TGT, 32'h38, 0);

    // asynchronous reset between edges
    step(); CtrlD = 8'h5A; InstrD = enc_i(1, 5'd5, 5'd4);
    push("pre_valide", S_VALIDE, 1, 1); push("pre_rd1e", S_RD1E, 32'h10, 1);
    push("pre_ctrle", S_CTRLE, 32'h5A, 1);
    step();
    @(negedge clk); #2;
    rst = 1'b1;
    push_now("arst_valide", S_VALIDE, 0); push_now("arst_ctrle", S_CTRLE, 0);
    push_now("arst_rd1e", S_RD1E, 0);
    #1 ->probe;
    step();
    step(); rst = 1'b0; InstrD = enc_i(0, 5'd1, 5'd2);
    push("x1_cleared", S_RD1E, 0, 1); push("post_valide", S_VALIDE, 1, 1);

    for (int k = 0; k < 20 && sb.size() > 0; k++) step();
    if (sb.size() != 0) begin
      total++; bad++;
      $display("FAIL drain: %0d entries left, want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/decode_stage_gen.md
Name: decode_stage_gen

Overview:
- Parametrised successor of the 5-stage pipeline decode stage. Holds the integer register file, generates immediates and resolves branches and JAL in ID.
- Branch operands get 4-way forwarding, and the comparator covers all six RV32I branch conditions.
- Target is a true PC-relative sum (PCD + imm).
- Registers the ID/EX bundle with independent stall (hold), flush (bubble) and a valid bit. Sits between the IF/ID register and the execute stage; the hazard unit drives StallE/FlushE/Forward*.

Parameters:
- XLEN, 32, datapath width in bits (32 or 64).
- NREG, 32, architectural register count (16 or 32); AW = $clog2(NREG).
- CTRL_W, 8, width of opaque control bundle from the controller, registered unchanged into EX.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- InstrD  in  32  instruction in ID
- PCD  in  XLEN  PC of instruction in ID
- ValidD  in  1  ID slot holds a real instruction
- CtrlD  in  CTRL_W  controller bundle (RegWrite, MemtoReg, MemWrite, ALUSrc, ALUControl…)
- BranchD  in  1  conditional branch in ID (from controller)
- JumpD  in  1  JAL in ID
- RegWriteW  in  1  writeback enable
- WriteRegW  in  AW  writeback address
- ResultW  in  XLEN  writeback data
- ALUOutM  in  XLEN  MEM-stage ALU result (forward source)
- ReadDataM  in  XLEN  MEM-stage load data (forward source)
- ForwardAD, ForwardBD  in  2  branch operand select: 0 RF, 1 ALUOutM, 2 ReadDataM, 3 ResultW
- StallE  in  1  hold ID/EX register
- FlushE  in  1  insert bubble into ID/EX
- PCSrcD  out  1  redirect fetch this cycle
- PCTargetD  out  XLEN  PCD + immediate
- CtrlE  out  CTRL_W  registered control
- ValidE  out  1  registered valid
- RD1E, RD2E, ImmE, PCE  out  XLEN  registered operands, immediate and PC
- RS1E, RS2E, RdE  out  AW  registered register indices

Behaviour:
- Register file: NREG×XLEN flops, written on posedge clk when RegWriteW and WriteRegW≠0. x0 reads 0 always.
  - Reads are combinational with write-through: if RegWriteW, WriteRegW==read addr and addr≠0, return ResultW in the same cycle.
  - rst clears all entries asynchronously.
  - Index bits above AW in InstrD are ignored (NREG=16 uses [18:15], [23:20], [10:7]).
- Immediates are selected by opcode: I (0010011/0000011/1100111), S (0100011), B (1100011), U (0110111/0010111), J (1101111). Other opcodes give 0. All are sign-extended to XLEN.
- Branch compare uses the forwarded operands A and B.
  - funct3 000 EQ, 001 NE, 100 LT signed, 101 GE signed, 110 LTU, 111 GEU. 010/011 are never taken.
  - Comparisons use full XLEN magnitude, with no subtraction-overflow error; signed compare must be correct for A=MIN, B=MAX.
- PCSrcD = ValidD & ((BranchD & taken) | JumpD). Purely combinational, zero latency.
- PCTargetD = PCD + imm, modulo 2^XLEN (wraps).
- ID/EX register, posedge clk, with priority rst > FlushE > StallE > load:
  - rst (async) or FlushE: every E output = 0, including ValidE=0.
  - StallE: all E outputs hold.
  - Otherwise: CtrlE←CtrlD masked to 0 when ValidD=0; ValidE←ValidD; RD1E/RD2E←RF reads including write-through, NOT branch-forwarded values; ImmE, PCE, RS1E, RS2E, RdE from ID.
  - FlushE and StallE together: flush wins.
- Reset mid-operation: E outputs go to 0 immediately (asynchronous); RF contents are lost. PCSrcD follows its inputs combinationally during reset, so the fetch stage must gate it with rst.
- Latency: ID→EX one cycle; branch resolution zero cycles.

Optional Feature:
- Macro DECODE_DBG_PORT_EN.
- Defined: adds ports DbgAddr (in, AW) and DbgData (out, XLEN), a combinational third read port without write-through. DbgData is 0 while rst is asserted.
- Undefined: the ports do not exist and no extra read mux is built.

Decomposition:
- Package decode_pkg holds:
  - opcode constants (OP_BRANCH, OP_JAL, OP_LUI, …)
  - funct3 branch codes
  - Forward-select encodings FWD_RF/FWD_ALUM/FWD_MEMD/FWD_WB
- One sub-module is natural: regfile_gen (parameters XLEN, NREG; two read ports plus an optional debug port, one write port, write-through).
- The immediate generator and branch comparator stay inline.

Test Plan:
- Write x5=0x0000_0010 and x6=0xFFFF_FFF0, then BLT x6,x5 with PCD=0x100 and imm=+8 → PCSrcD=1, PCTargetD=0x108. The same operands with BLTU → PCSrcD=0.
- Same-cycle write x7=0xABCD and read x7 in ID → RD1 path shows 0xABCD. Write x0=0x1234 → reads of x0 return 0.
- BEQ with ForwardAD=1 (ALUOutM=0x55), ForwardBD=2 (ReadDataM=0x55) and RF values differing → PCSrcD=1. ForwardBD=3 with ResultW=0x56 → PCSrcD=0.
- Load a valid instruction, then StallE=1 for 3 cycles while ID changes → E outputs constant. Then FlushE=1 and StallE=1 together → next edge all E outputs 0, ValidE=0.
- JAL with PCD=0xFFFF_FFFC and imm=+8 → PCSrcD=1, PCTargetD=0x0000_0004 (wrap). With ValidD=0 → PCSrcD=0 and CtrlE=0 next cycle.
- Assert rst asynchronously between clock edges with ValidE=1 → ValidE, CtrlE and RD1E go to 0 before the next edge. After release, x1 reads 0.
